regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port integer register file with a busy-bit scoreboard, for the pipelined/dual-issue NPC core.
//  - Replaces the single-write/two-read regfile: N combinational read ports, M synchronous write ports, resettable storage.
//  - Each read port reports whether its operand has a pending (issued, not written back) producer.
// PARAMETERS
//  DATA_W    64  register width (CPU_WIDTH)
//  ADDR_W    5   register index width (REG_ADDRW)
//  NUM_REGS  32  register count (REG_COUNT); must be <= 2**ADDR_W
//  NRD       2   number of read ports
//  NWR       2   number of write (writeback) ports
// PORTS
//  clk        in   1             core clock, rising edge
//  rst_n      in   1             async active-low reset
//  wen        in   NWR           per-port write enable
//  waddr      in   NWR*ADDR_W    per-port write index, port k at [k*ADDR_W +: ADDR_W]
//  wdata      in   NWR*DATA_W    per-port write data
//  raddr      in   NRD*ADDR_W    per-port read index
//  rdata      out  NRD*DATA_W    per-port read data, combinational
//  rbusy      out  NRD           1 = read operand has a pending producer
//  issue_en   in   1             instruction with destination issued this cycle
//  issue_addr in   ADDR_W        its destination index
//  flush      in   1             clear all busy bits (pipeline flush)
// BEHAVIOUR
//  - Reset (rst_n=0, async): all registers = 0, all busy bits = 0; hence rdata = 0, rbusy = 0 during and after reset.
//  - Register 0: writes ignored; reads return 0; busy[0] never set, issue to x0 ignored.
//  - Write: on posedge clk, if wen[k] and waddr[k]!=0, rf[waddr[k]] <= wdata[k].
//    Same index on several ports: highest-numbered port wins.
//  - Indices >= NUM_REGS: writes dropped, reads return 0, rbusy = 0.
//  - Read: rdata[j] = rf[raddr[j]] (combinational, 0-cycle latency).
//    Without bypass, data written at edge t is visible after edge t.
//  - Scoreboard busy[NUM_REGS-1:0], updated on posedge clk:
//    - Clear busy[waddr[k]] for every k with wen[k].
//    - Then set busy[issue_addr] if issue_en. Set beats clear on the same index: the new producer owns the register.
//    - flush: all busy bits <= 0. flush beats issue_en in the same cycle.
//  - rbusy[j] = busy[raddr[j]], with adjustments only as given under CONFIGURATION.
//  - Async reset mid-operation discards in-flight writes and all busy state immediately; no partial writes.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//    - Write-to-read forwarding: if wen[k] and waddr[k]==raddr[j]!=0 in the same cycle, rdata[j] = wdata[k] (highest k wins).
//    - rbusy[j] is forced to 0 in that case.
//  REGFILE_BYPASS_EN undefined:
//    - rdata comes from storage only; rbusy reflects busy bits as registered.
//    - The pipeline waits one extra cycle after writeback.
// STRUCTURE
//  - Package rf_pkg: DATA_W/ADDR_W/NUM_REGS defaults (from define.sv values), typedef reg_idx_t (logic [ADDR_W-1:0]),
//    typedef reg_data_t (logic [DATA_W-1:0]), localparam REG_ZERO = '0.
//  - Sub-module rf_scoreboard: busy vector, issue/clear/flush priority, rst_n reset.
//  - Storage array, write-priority loops and read muxes/bypass live in regfile_mp.
// TESTING
//  1. Reset: assert rst_n=0 mid-run after writes -> all rdata=0, rbusy=0 immediately; reads stay 0 after release.
//  2. x0: wen[0]=1, waddr=0, wdata=64'hDEAD; issue_en, issue_addr=0 -> raddr=0 gives 0, rbusy=0.
//  3. Write conflict: port0 and port1 both write x5 (64'h1111, 64'h2222) -> next cycle rf[5] reads 64'h2222.
//  4. Scoreboard: issue x7 at cycle 1 -> rbusy=1 on raddr=7 from cycle 2.
//     wen x7 at cycle 4 with issue_en x7 same cycle -> busy stays 1.
//     wen x7 at cycle 6 alone -> busy clears to 0 at cycle 7.
//  5. Flush: busy x3,x9 set; flush=1 with issue_en x4 -> all busy 0 next cycle, including x4.
//  6. Bypass: wen x10=64'hCAFE, raddr=10 same cycle.
//     With REGFILE_BYPASS_EN: rdata=64'hCAFE, rbusy=0 that cycle.
//     Without it: old value that cycle, 64'hCAFE the next.

Source files
------------

// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file widths, index/data types and the x0 constant.
package rf_pkg;
  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] reg_data_t;
  localparam reg_idx_t REG_ZERO = '0;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits; writeback clears, issue sets (issue wins), flush clears all.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W   = rf_pkg::ADDR_W,
  parameter int NUM_REGS = rf_pkg::NUM_REGS,
  parameter int NWR      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NWR-1:0]        wen,
  input  logic [NWR*ADDR_W-1:0] waddr,
  input  logic                  issue_en,
  input  logic [ADDR_W-1:0]     issue_addr,
  input  logic                  flush,
  output logic [NUM_REGS-1:0]   busy
);
  logic [NUM_REGS-1:0] nxt;
  always_comb begin
    nxt = busy;
    for (int k = 0; k < NWR; k++)
      if (wen[k] && 32'(waddr[k*ADDR_W +: ADDR_W]) < NUM_REGS) nxt[waddr[k*ADDR_W +: ADDR_W]] = 1'b0;
    if (issue_en && issue_addr != '0 && 32'(issue_addr) < NUM_REGS) nxt[issue_addr] = 1'b1;
    if (flush) nxt = '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) busy <= '0;
    else busy <= nxt;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: NRD-read / NWR-write register file with busy scoreboard.
// Optional write-to-read forwarding under REGFILE_BYPASS_EN.
module regfile_mp
  import rf_pkg::*;
#(
  parameter int DATA_W   = rf_pkg::DATA_W,
  parameter int ADDR_W   = rf_pkg::ADDR_W,
  parameter int NUM_REGS = rf_pkg::NUM_REGS,
  parameter int NRD      = 2,
  parameter int NWR      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NWR-1:0]        wen,
  input  logic [NWR*ADDR_W-1:0] waddr,
  input  logic [NWR*DATA_W-1:0] wdata,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  output logic [NRD-1:0]        rbusy,
  input  logic                  issue_en,
  input  logic [ADDR_W-1:0]     issue_addr,
  input  logic                  flush
);
  logic [DATA_W-1:0]   rf [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  function automatic logic ok(input logic [ADDR_W-1:0] a);
    return a != '0 && 32'(a) < NUM_REGS;
  endfunction
  rf_scoreboard #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .NWR(NWR)) u_sb (
    .clk, .rst_n, .wen, .waddr, .issue_en, .issue_addr, .flush, .busy
  );
  // Ascending port order: the last NBA to an index (highest port) wins.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    else for (int k = 0; k < NWR; k++)
      if (wen[k] && ok(waddr[k*ADDR_W +: ADDR_W])) rf[waddr[k*ADDR_W +: ADDR_W]] <= wdata[k*DATA_W +: DATA_W];
  for (genvar j = 0; j < NRD; j++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic              rb;
    assign ra = raddr[j*ADDR_W +: ADDR_W];
    always_comb begin
      rd = ok(ra) ? rf[ra] : '0;
      rb = ok(ra) && busy[ra];
`ifdef REGFILE_BYPASS_EN
      for (int k = 0; k < NWR; k++)
        if (ok(ra) && wen[k] && waddr[k*ADDR_W +: ADDR_W] == ra) begin
          rd = wdata[k*DATA_W +: DATA_W];
          rb = 1'b0;
        end
`endif
    end
    assign rdata[j*DATA_W +: DATA_W] = rd;
    assign rbusy[j] = rb;
  end
endmodule
